// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, sequencer state encoding and IR field positions for the control unit
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  // states are ordered so that straight-line sequencing is state + 1
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;
endpackage

// File: rtl/cpu_opcode_class.sv
// cpu_opcode_class: one-hot classification of an opcode into binary/unary/nop/halt/illegal
module cpu_opcode_class
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output logic            binary,
  output logic            unary,
  output logic            nop,
  output logic            halt,
  output logic            illegal
);
  assign binary  = opcode inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR};
  assign unary   = opcode inside {OP_NEG, OP_NOT};
  assign nop     = opcode == OP_NOP;
  assign halt    = opcode == OP_HALT;
  assign illegal = !(binary | unary | nop | halt);
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: Moore fetch/decode/execute sequencer driving Datapath strobes; ILLEGAL_TRAP_EN halts on illegal opcodes
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic            stop,
  output logic            pc_out,
  output logic            zlow_out,
  output logic            mdr_out,
  output logic            mar_in,
  output logic            z_in,
  output logic            pc_in,
  output logic            mdr_in,
  output logic            ir_in,
  output logic            y_in,
  output logic            inc_pc,
  output logic            read,
  output logic [OP_W-1:0] alu_op,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            run,
  output logic            illegal
);
  logic [2:0] state, next;
  logic [OP_W-1:0] op;
  logic c_bin, c_un, c_nop, c_halt, c_ill;
  logic t0, t1, t2, t3, t4, t5, last, trap, nop_like, alu_step;
  logic unused_ir;
  assign op = ir[IR_W-1 -: OP_W];
  assign unused_ir = ^ir[IR_W-OP_W-1:0];
  cpu_opcode_class #(.OP_W(OP_W)) u_class (
    .opcode (op),
    .binary (c_bin),
    .unary  (c_un),
    .nop    (c_nop),
    .halt   (c_halt),
    .illegal(c_ill)
  );
  assign t0 = state == S_T0;
  assign t1 = state == S_T1;
  assign t2 = state == S_T2;
  assign t3 = state == S_T3;
  assign t4 = state == S_T4;
  assign t5 = state == S_T5;
`ifdef ILLEGAL_TRAP_EN
  logic ill_q;
  // sticky illegal flag, raised on the edge that traps into HALT
  always_ff @(posedge clk or posedge reset)
    if (reset) ill_q <= 1'b0;
    else if (t3 && c_ill) ill_q <= 1'b1;
  assign illegal  = ill_q;
  assign trap     = t3 & (c_halt | c_ill);
  assign nop_like = c_nop;
`else
  assign illegal  = 1'b0;
  assign trap     = t3 & c_halt;
  assign nop_like = c_nop | c_ill;
`endif
  // instruction boundary: the final execute step of each opcode class
  assign last = t5 | (t4 & c_un) | (t3 & nop_like);
  // next-state selection; stop only matters at the boundary
  always_comb
    next = state == S_RST  ? S_T0 :
           state == S_HALT ? S_HALT :
           last            ? (stop ? S_HALT : S_T0) :
           trap            ? S_HALT : state + 3'd1;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_RST;
    else state <= next;
  assign alu_step = (t3 & c_un) | (t4 & c_bin);
  assign pc_out   = t0;
  assign mar_in   = t0;
  assign inc_pc   = t0;
  assign z_in     = t0 | alu_step;
  assign zlow_out = t1 | (t4 & c_un) | (t5 & c_bin);
  assign pc_in    = t1;
  assign read     = t1;
  assign mdr_in   = t1;
  assign mdr_out  = t2;
  assign ir_in    = t2;
  assign y_in     = t3 & c_bin;
  assign grb      = t3 & (c_bin | c_un);
  assign grc      = t4 & c_bin;
  assign r_out    = grb | grc;
  assign gra      = (t4 & c_un) | (t5 & c_bin);
  assign r_in     = gra;
  assign alu_op   = alu_step ? op : '0;
  assign run      = state != S_HALT;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed-vector checks of the control unit strobe sequences
module tb_cpu_control_unit;
  logic clk = 0, reset = 1, stop = 0;
  logic [31:0] ir = '0;
  logic pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read;
  logic gra, grb, grc, r_in, r_out, run, illegal;
  logic [4:0] alu_op;
  int assertions = 0, failures = 0;

  localparam logic [22:0] PCO = 23'd1 << 22, ZLO = 23'd1 << 21, MDO = 23'd1 << 20, MAI = 23'd1 << 19;
  localparam logic [22:0] ZI  = 23'd1 << 18, PCI = 23'd1 << 17, MDI = 23'd1 << 16, IRI = 23'd1 << 15;
  localparam logic [22:0] YI  = 23'd1 << 14, INC = 23'd1 << 13, RD  = 23'd1 << 12, GA  = 23'd1 << 11;
  localparam logic [22:0] GB  = 23'd1 << 10, GC  = 23'd1 << 9,  RI  = 23'd1 << 8,  RO  = 23'd1 << 7;
  localparam logic [22:0] RUN = 23'd1 << 6,  ILL = 23'd1 << 5;
  localparam logic [22:0] E_RST = RUN;
  localparam logic [22:0] E_T0 = PCO | MAI | INC | ZI | RUN;
  localparam logic [22:0] E_T1 = ZLO | PCI | RD | MDI | RUN;
  localparam logic [22:0] E_T2 = MDO | IRI | RUN;
  localparam logic [22:0] E_B3 = GB | RO | YI | RUN;
  localparam logic [22:0] E_B4 = GC | RO | ZI | RUN;
  localparam logic [22:0] E_B5 = ZLO | GA | RI | RUN;
  localparam logic [22:0] E_U3 = GB | RO | ZI | RUN;
  localparam logic [22:0] E_U4 = ZLO | GA | RI | RUN;
  localparam logic [22:0] E_NOP = RUN;
  localparam logic [22:0] E_HALT = 23'd0;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .stop(stop),
    .pc_out(pc_out), .zlow_out(zlow_out), .mdr_out(mdr_out), .mar_in(mar_in),
    .z_in(z_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in),
    .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] obs();
    return {pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read,
            gra, grb, grc, r_in, r_out, run, illegal, alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_t0();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    assertions++;
    if (obs() !== E_RST) begin failures++; $display("FAIL reset_hold: got %h expected %h", obs(), E_RST); end
    reset = 0;
    #2;
    assertions++;
    if (obs() !== E_RST) begin failures++; $display("FAIL reset_release: got %h expected %h", obs(), E_RST); end
  endtask

  task automatic test_and();
    logic [22:0] e [0:6];
    e = '{E_T0, E_T1, E_T2, E_B3, E_B4 | 23'd9, E_B5, E_T0};
    ir = 32'h4A920000;
    for (int i = 0; i < 7; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL and step %0d: got %h expected %h", i, obs(), e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] e [0:5];
    e = '{E_T1, E_T2, E_B3, E_B4 | 23'd3, E_B5, E_T0};
    ir = 32'h1A920000;
    for (int i = 0; i < 6; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL add_b2b step %0d: got %h expected %h", i, obs(), e[i]); end
    end
  endtask

  task automatic test_unary();
    logic [22:0] e [0:4];
    e = '{E_T1, E_T2, E_U3 | 23'd16, E_U4, E_T0};
    ir = 32'h80980000;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL neg step %0d: got %h expected %h", i, obs(), e[i]); end
    end
    e = '{E_T1, E_T2, E_U3 | 23'd17, E_U4, E_T0};
    ir = 32'h88980000;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL not step %0d: got %h expected %h", i, obs(), e[i]); end
    end
  endtask

  task automatic test_nop();
    logic [22:0] e [0:3];
    e = '{E_T1, E_T2, E_NOP, E_T0};
    ir = 32'hC8000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL nop step %0d: got %h expected %h", i, obs(), e[i]); end
    end
  endtask

  task automatic test_stop();
    logic [22:0] e [0:5];
    e = '{E_B3, E_B4 | 23'd9, E_B5, E_HALT, E_HALT, E_HALT};
    ir = 32'h4A920000;
    tick();
    tick();
    assertions++;
    if (obs() !== E_T2) begin failures++; $display("FAIL stop_t2: got %h expected %h", obs(), E_T2); end
    stop = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL stop step %0d: got %h expected %h", i, obs(), e[i]); end
    end
    stop = 0;
    to_t0();
    assertions++;
    if (obs() !== E_T0) begin failures++; $display("FAIL stop_recover: got %h expected %h", obs(), E_T0); end
  endtask

  task automatic test_halt();
    logic [22:0] e [0:3];
    e = '{E_T1, E_T2, E_NOP, E_HALT};
    ir = 32'hD0000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL halt step %0d: got %h expected %h", i, obs(), e[i]); end
    end
    ir = 32'h4A920000;
    for (int i = 0; i < 10; i++) begin
      tick();
      assertions++;
      if (obs() !== E_HALT) begin failures++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs(), E_HALT); end
    end
    reset = 1;
    #1;
    assertions++;
    if (obs() !== E_RST) begin failures++; $display("FAIL halt_reset: got %h expected %h", obs(), E_RST); end
    tick();
    reset = 0;
    tick();
    assertions++;
    if (obs() !== E_T0) begin failures++; $display("FAIL halt_restart: got %h expected %h", obs(), E_T0); end
  endtask

  task automatic test_reset_mid();
    ir = 32'h4A920000;
    for (int i = 0; i < 4; i++) tick();
    assertions++;
    if (obs() !== (E_B4 | 23'd9)) begin failures++; $display("FAIL mid_t4: got %h expected %h", obs(), E_B4 | 23'd9); end
    #1;
    reset = 1;
    #1;
    assertions++;
    if (obs() !== E_RST) begin failures++; $display("FAIL mid_reset: got %h expected %h", obs(), E_RST); end
    tick();
    reset = 0;
    tick();
    assertions++;
    if (obs() !== E_T0) begin failures++; $display("FAIL mid_restart: got %h expected %h", obs(), E_T0); end
  endtask

  task automatic test_illegal();
    logic [22:0] e [0:4];
`ifdef ILLEGAL_TRAP_EN
    e = '{E_T1, E_T2, E_NOP, ILL, ILL};
`else
    e = '{E_T1, E_T2, E_NOP, E_T0, E_T1};
`endif
    ir = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertions++;
      if (obs() !== e[i]) begin failures++; $display("FAIL illegal step %0d: got %h expected %h", i, obs(), e[i]); end
    end
    to_t0();
    assertions++;
    if (obs() !== E_T0) begin failures++; $display("FAIL illegal_recover: got %h expected %h", obs(), E_T0); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_unary();
    test_nop();
    test_stop();
    test_halt();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
